// File: rtl/usb_rx_unstuffer.sv
// usb_rx_unstuffer: NRZI decode, USB bit unstuffing, LSB-first byte assembly.
// Optional byte assembler is built only when USB_RX_BYTE_ASM_EN is defined.

module usb_rx_unstuffer #(
  parameter int STUFF_LEN = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       d_line,
  input  logic       bit_strobe,
  input  logic       clear,
  output logic       serial_out,
  output logic       shift_en,
  output logic       stuff_err,
  output logic [7:0] rx_byte,
  output logic       byte_valid
);

  localparam int CW = $clog2(STUFF_LEN + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STUFF_LEN);

  logic          prev_line;
  logic [CW-1:0] ones_cnt;
  logic [CW-1:0] ones_nxt;
  logic          dec;
  logic          at_lim;
  logic          is_data;
  logic          is_viol;

  // Decode the sampled level and classify it as data, stuff or violation
  always_comb begin
    dec      = (d_line == prev_line);
    at_lim   = (ones_cnt == LIMIT);
    is_data  = 1'b0;
    is_viol  = 1'b0;
    ones_nxt = ones_cnt;
    unique case (1'b1)
      !at_lim: begin
        is_data  = 1'b1;
        ones_nxt = dec ? ones_cnt + 1'b1 : '0;
      end
      at_lim && !dec: begin
        ones_nxt = '0;
      end
      at_lim && dec: begin
        is_viol = 1'b1;
      end
    endcase
  end

  // Line history, ones run, sticky error and the serial feed to the CRC
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      prev_line  <= 1'b1;
      ones_cnt   <= '0;
      serial_out <= 1'b0;
      shift_en   <= 1'b0;
      stuff_err  <= 1'b0;
    end else begin
      shift_en <= 1'b0;
      if (bit_strobe) begin
        prev_line <= d_line;
        ones_cnt  <= ones_nxt;
        if (is_data) begin
          serial_out <= dec;
          shift_en   <= 1'b1;
        end
        if (is_viol) begin
          stuff_err <= 1'b1;
        end
      end
    end
  end

`ifdef USB_RX_BYTE_ASM_EN
  logic [6:0] shreg;
  logic [2:0] bit_cnt;

  // Shift data bits in LSB-first; the eighth bit completes the byte directly
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      rx_byte    <= 8'h00;
      byte_valid <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      if (bit_strobe && is_data) begin
        if (bit_cnt == 3'd7) begin
          rx_byte    <= {dec, shreg};
          byte_valid <= 1'b1;
        end
        shreg   <= {dec, shreg[6:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end
`else
  assign rx_byte    = 8'h00;
  assign byte_valid = 1'b0;
`endif

endmodule

// File: tb/tb_usb_rx_unstuffer.sv
// tb_usb_rx_unstuffer: directed and randomized checks of usb_rx_unstuffer
// against a transmitter-side encoder and a line-level reference model.

module tb_usb_rx_unstuffer;

  localparam int SL = 6;
`ifdef USB_RX_BYTE_ASM_EN
  localparam bit ASM = 1'b1;
`else
  localparam bit ASM = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       d_line = 1'b1;
  logic       bit_strobe = 1'b0;
  logic       clear = 1'b0;
  logic       serial_out;
  logic       shift_en;
  logic       stuff_err;
  logic [7:0] rx_byte;
  logic       byte_valid;

  usb_rx_unstuffer #(.STUFF_LEN(SL)) dut (
    .clk(clk),
    .rst(rst),
    .d_line(d_line),
    .bit_strobe(bit_strobe),
    .clear(clear),
    .serial_out(serial_out),
    .shift_en(shift_en),
    .stuff_err(stuff_err),
    .rx_byte(rx_byte),
    .byte_valid(byte_valid)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // observed stream (sampled on the falling edge)
  int           o_n;
  int           o_bn;
  logic [255:0] o_bits;
  logic [255:0] o_bytes;

  // reference model
  bit           m_prev;
  int           m_ones;
  logic         m_err;
  int           m_n;
  int           m_bn;
  logic [255:0] m_bits;
  logic [255:0] m_bytes;
  logic [7:0]   m_acc;
  int           m_cnt;
  logic [7:0]   m_last;

  // transmitter encoder state
  bit tx_level;
  int tx_ones;

  always @(negedge clk) begin
    if (shift_en) begin
      if (o_n < 256) o_bits[o_n] = serial_out;
      o_n++;
    end
    if (byte_valid) begin
      if (o_bn < 32) o_bytes[o_bn*8 +: 8] = rx_byte;
      o_bn++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic clr_all();
    o_n = 0; o_bn = 0; o_bits = '0; o_bytes = '0;
    m_n = 0; m_bn = 0; m_bits = '0; m_bytes = '0;
  endtask

  task automatic model_reset();
    m_prev = 1'b1; m_ones = 0; m_err = 1'b0;
    m_acc = 8'h00; m_cnt = 0; m_last = 8'h00;
    tx_level = 1'b1; tx_ones = 0;
  endtask

  task automatic model_bit(input bit lvl);
    bit dec;
    dec = (lvl == m_prev);
    m_prev = lvl;
    if (m_ones < SL) begin
      if (m_n < 256) m_bits[m_n] = dec;
      m_n++;
      m_ones = dec ? m_ones + 1 : 0;
      m_acc[m_cnt] = dec;
      m_cnt++;
      if (m_cnt == 8) begin
        m_cnt = 0;
        if (ASM) begin
          if (m_bn < 32) m_bytes[m_bn*8 +: 8] = m_acc;
          m_bn++;
          m_last = m_acc;
        end
      end
    end else if (!dec) begin
      m_ones = 0;
    end else begin
      m_err = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic strobe(input bit lvl);
    d_line = lvl;
    bit_strobe = 1'b1;
    @(posedge clk); #1;
    bit_strobe = 1'b0;
    model_bit(lvl);
  endtask

  task automatic do_clear(input bit stb, input bit lvl);
    d_line = lvl;
    bit_strobe = stb;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    bit_strobe = 1'b0;
    model_reset();
  endtask

  // transmitter: NRZI encode one data bit, inserting a stuff 0 after 6 ones
  task automatic tx_bit(input bit b);
    if (b) begin
      strobe(tx_level);
      tx_ones++;
      if (tx_ones == SL) begin
        tx_level = ~tx_level;
        strobe(tx_level);
        tx_ones = 0;
      end
    end else begin
      tx_level = ~tx_level;
      strobe(tx_level);
      tx_ones = 0;
    end
  endtask

  task automatic tx_byte(input logic [7:0] v, input bit gaps);
    for (int i = 0; i < 8; i++) begin
      tx_bit(v[i]);
      if (gaps) idle($urandom_range(0, 2));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (serial_out !== 1'b0) begin
      bad++; $display("FAIL reset_serial_out got=%b exp=0", serial_out);
    end
    total++;
    if (shift_en !== 1'b0) begin
      bad++; $display("FAIL reset_shift_en got=%b exp=0", shift_en);
    end
    total++;
    if (stuff_err !== 1'b0) begin
      bad++; $display("FAIL reset_stuff_err got=%b exp=0", stuff_err);
    end
    total++;
    if (rx_byte !== 8'h00) begin
      bad++; $display("FAIL reset_rx_byte got=%h exp=00", rx_byte);
    end
    total++;
    if (byte_valid !== 1'b0) begin
      bad++; $display("FAIL reset_byte_valid got=%b exp=0", byte_valid);
    end
    rst = 1'b0;
    model_reset();
    clr_all();
    strobe(1'b1);
    total++;
    if (serial_out !== 1'b1 || shift_en !== 1'b1) begin
      bad++;
      $display("FAIL first_bit got=%b/%b exp=1/1", serial_out, shift_en);
    end
    idle(2);
    total++;
    if (o_n !== 1) begin
      bad++; $display("FAIL first_bit_pulses got=%0d exp=1", o_n);
    end
  endtask

  task automatic test_byte();
    bit lv [8] = '{1, 0, 0, 1, 1, 1, 1, 1};
    do_clear(1'b0, 1'b1);
    idle(1);
    clr_all();
    for (int i = 0; i < 8; i++) strobe(lv[i]);
    idle(2);
    total++;
    if (o_n !== 8 || o_bits[7:0] !== 8'hF5) begin
      bad++;
      $display("FAIL byte_bits got=%0d/%h exp=8/f5", o_n, o_bits[7:0]);
    end
    total++;
    if (o_bn !== (ASM ? 1 : 0)) begin
      bad++; $display("FAIL byte_valid_cnt got=%0d exp=%0d", o_bn, ASM);
    end
    total++;
    if (rx_byte !== (ASM ? 8'hF5 : 8'h00)) begin
      bad++; $display("FAIL byte_value got=%h", rx_byte);
    end
  endtask

  task automatic test_stuff();
    do_clear(1'b0, 1'b1);
    idle(1);
    clr_all();
    for (int i = 0; i < 6; i++) strobe(1'b1);
    strobe(1'b0);
    strobe(1'b0);
    idle(2);
    total++;
    if (o_n !== 7 || o_bits[6:0] !== 7'h7F) begin
      bad++;
      $display("FAIL stuff_bits got=%0d/%h exp=7/7f", o_n, o_bits[6:0]);
    end
    total++;
    if (serial_out !== 1'b1 || stuff_err !== 1'b0) begin
      bad++;
      $display("FAIL stuff_last got=%b err=%b exp=1/0", serial_out, stuff_err);
    end
  endtask

  task automatic test_violation();
    do_clear(1'b0, 1'b1);
    idle(1);
    clr_all();
    for (int i = 0; i < 7; i++) strobe(1'b1);
    idle(2);
    total++;
    if (o_n !== 6) begin
      bad++; $display("FAIL viol_pulses got=%0d exp=6", o_n);
    end
    total++;
    if (stuff_err !== 1'b1) begin
      bad++; $display("FAIL viol_err got=%b exp=1", stuff_err);
    end
    idle(5);
    total++;
    if (stuff_err !== 1'b1) begin
      bad++; $display("FAIL viol_err_held got=%b exp=1", stuff_err);
    end
    do_clear(1'b0, 1'b1);
    idle(1);
    total++;
    if (stuff_err !== 1'b0) begin
      bad++; $display("FAIL viol_err_clear got=%b exp=0", stuff_err);
    end
  endtask

  task automatic test_clear_mid();
    do_clear(1'b0, 1'b1);
    idle(1);
    clr_all();
    strobe(1'b1);
    strobe(1'b0);
    strobe(1'b1);
    do_clear(1'b1, 1'b0);
    idle(2);
    total++;
    if (o_n !== 3) begin
      bad++; $display("FAIL clear_drop got=%0d exp=3", o_n);
    end
    tx_byte(8'h5A, 1'b0);
    idle(2);
    total++;
    if (o_n !== 11 || o_bits[10:3] !== 8'h5A) begin
      bad++;
      $display("FAIL clear_fresh_bits got=%0d/%h exp=11/5a", o_n, o_bits[10:3]);
    end
    total++;
    if (o_bn !== (ASM ? 1 : 0) || rx_byte !== (ASM ? 8'h5A : 8'h00)) begin
      bad++;
      $display("FAIL clear_fresh_byte got=%0d/%h", o_bn, rx_byte);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] c;
    logic [15:0] r;
    logic [15:0] e;
    logic [7:0]  bv [2] = '{8'hA5, 8'h3C};
    bit          fb;
    do_clear(1'b0, 1'b1);
    idle(1);
    clr_all();
    tx_byte(8'hA5, 1'b0);
    tx_byte(8'h3C, 1'b0);
    idle(2);
    total++;
    if (o_n !== 16 || o_bits[15:0] !== 16'h3CA5) begin
      bad++;
      $display("FAIL b2b_bits got=%0d/%h exp=16/3ca5", o_n, o_bits[15:0]);
    end
    total++;
    if (o_bn !== (ASM ? 2 : 0)) begin
      bad++; $display("FAIL b2b_bytes got=%0d", o_bn);
    end
    total++;
    if (o_bytes[15:0] !== (ASM ? 16'h3CA5 : 16'h0000)) begin
      bad++; $display("FAIL b2b_byte_vals got=%h", o_bytes[15:0]);
    end
    c = 16'hFFFF;
    for (int i = 0; i < 16; i++) begin
      fb = c[15] ^ o_bits[i];
      c = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h8005;
    end
    for (int i = 0; i < 16; i++) r[i] = c[15-i];
    e = 16'hFFFF;
    for (int k = 0; k < 2; k++) begin
      e = e ^ {8'h00, bv[k]};
      for (int j = 0; j < 8; j++) begin
        e = e[0] ? ((e >> 1) ^ 16'hA001) : (e >> 1);
      end
    end
    total++;
    if (r !== e) begin
      bad++; $display("FAIL b2b_crc got=%h exp=%h", r, e);
    end
  endtask

  task automatic test_random_tx();
    logic [159:0] exp;
    logic [7:0]   v;
    do_clear(1'b0, 1'b1);
    idle(1);
    clr_all();
    for (int k = 0; k < 20; k++) begin
      v = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
      exp[k*8 +: 8] = v;
      tx_byte(v, k[0]);
    end
    idle(2);
    total++;
    if (o_n !== 160 || o_bits[159:0] !== exp) begin
      bad++; $display("FAIL rtx_bits got=%0d exp=160", o_n);
    end
    total++;
    if (stuff_err !== 1'b0) begin
      bad++; $display("FAIL rtx_err got=%b exp=0", stuff_err);
    end
    total++;
    if (o_bn !== (ASM ? 20 : 0)) begin
      bad++; $display("FAIL rtx_byte_cnt got=%0d", o_bn);
    end
    total++;
    if (o_bytes[159:0] !== (ASM ? exp : 160'h0)) begin
      bad++; $display("FAIL rtx_bytes last got=%h", o_bytes[159:152]);
    end
  endtask

  task automatic test_random_line();
    bit lvl;
    for (int it = 0; it < 4; it++) begin
      do_clear(1'b0, 1'b1);
      idle(1);
      clr_all();
      lvl = 1'b1;
      for (int i = 0; i < 160; i++) begin
        if ($urandom_range(0, 4) == 0) lvl = ~lvl;
        strobe(lvl);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end
      idle(2);
      total++;
      if (o_n !== m_n || o_bits !== m_bits) begin
        bad++;
        $display("FAIL rline_bits it=%0d got=%0d exp=%0d", it, o_n, m_n);
      end
      total++;
      if (stuff_err !== m_err) begin
        bad++;
        $display("FAIL rline_err it=%0d got=%b exp=%b", it, stuff_err, m_err);
      end
      total++;
      if (o_bn !== m_bn || o_bytes !== m_bytes) begin
        bad++;
        $display("FAIL rline_bytes it=%0d got=%0d exp=%0d", it, o_bn, m_bn);
      end
      total++;
      if (rx_byte !== m_last) begin
        bad++;
        $display("FAIL rline_rx_byte it=%0d got=%h exp=%h", it, rx_byte, m_last);
      end
    end
  endtask

  initial begin
    model_reset();
    clr_all();
    test_reset();
    test_byte();
    test_stuff();
    test_violation();
    test_clear_mid();
    test_back_to_back();
    test_random_tx();
    test_random_line();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
